beat_scheduler: RTL and testbench

//   Transport and step-timing controller for the sequencer. Converts the user tempo (bpm, 5..200)

---
 rtl/beat_scheduler_pkg.sv | 28 ++
 rtl/beat_scheduler_if.sv | 41 ++++
 rtl/beat_scheduler_step_rate_nco.sv | 50 +++++
 rtl/beat_scheduler.sv | 140 ++++++++++++++
 tb/tb_beat_scheduler.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/beat_scheduler_pkg.sv
// rtl/beat_scheduler_pkg.sv - shared transport encodings and tempo limits for the beat scheduler
//
// Purpose: transport state encoding, tempo bounds and the tempo clamp helper
// shared by the scheduler top and its bench.
package beat_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } transport_e;

  localparam logic [7:0] BPM_MIN     = 8'd5;
  localparam logic [7:0] BPM_MAX     = 8'd200;
  localparam logic [7:0] BPM_DEFAULT = 8'd120;

  // Tempo requests outside the supported range (including 0) are pulled to the nearest bound.
  function automatic logic [7:0] clamp_bpm(input logic [7:0] b);
    if (b < BPM_MIN) begin
      return BPM_MIN;
    end else if (b > BPM_MAX) begin
      return BPM_MAX;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/beat_scheduler_if.sv
// rtl/beat_scheduler_if.sv - transport control and step strobe bundle of the beat scheduler
//
// Purpose: groups the tempo/transport controls and the step/beat/bar strobes.
// Signals:
//   bpm        requested tempo (sampled at step boundaries and on start)
//   play       1-cycle start / pause / resume toggle
//   stop       1-cycle stop and rewind
//   step_tick  1-cycle strobe on each step advance (and downbeat on start)
//   beat_tick  1-cycle strobe with step_tick on beat-aligned steps
//   bar_tick   1-cycle strobe with step_tick on step 0
//   step_idx   current step 0..STEPS-1
//   running    high while transport is running
//   bpm_active tempo currently in effect
// Modports: master = transport controller side, slave = scheduler side.
interface beat_scheduler_if #(
  parameter int STEPS = 16
);

  localparam int IDX_W = $clog2(STEPS);

  logic [7:0]       bpm;
  logic             play;
  logic             stop;
  logic             step_tick;
  logic             beat_tick;
  logic             bar_tick;
  logic [IDX_W-1:0] step_idx;
  logic             running;
  logic [7:0]       bpm_active;

  modport master (
    output bpm, play, stop,
    input  step_tick, beat_tick, bar_tick, step_idx, running, bpm_active
  );

  modport slave (
    input  bpm, play, stop,
    output step_tick, beat_tick, bar_tick, step_idx, running, bpm_active
  );

endinterface

// File: rtl/beat_scheduler_step_rate_nco.sv
// rtl/beat_scheduler_step_rate_nco.sv - phase accumulator producing one wrap per step period
//
// Purpose: accumulates inc every enabled clock; when the sum reaches LIMIT the
// remainder is carried over, so the long-run step rate is exact with no drift.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       synchronous clear of the accumulator (stop / fresh start)
//   en        accumulate this clock
//   inc       phase increment per clock (bpm * SUBDIV)
//   wrap      combinational: this enabled clock crosses LIMIT (a step boundary)
module step_rate_nco #(
  parameter longint unsigned LIMIT = 64'd6000,
  parameter int              ACC_W = 13,
  parameter int              INC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  output logic             wrap
);

  localparam logic [ACC_W:0] LIMIT_S = (ACC_W+1)'(LIMIT);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // One extra bit on the sum so acc + inc can never overflow before the compare.
  always_comb begin
    sum = {1'b0, acc} + (ACC_W+1)'(inc);
  end

  assign wrap = en && (sum >= LIMIT_S);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      if (wrap) begin
        acc <= ACC_W'(sum - LIMIT_S);
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/beat_scheduler.sv
// rtl/beat_scheduler.sv - transport FSM and step/beat/bar strobe generator for the sequencer
//
// Purpose: converts tempo into sample-accurate step, beat and bar strobes and owns
// the play/pause/stop transport. Tempo changes apply only on step boundaries.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  beat_scheduler_if.slave: bpm/play/stop in, strobes/step_idx/running/bpm_active out
module beat_scheduler
  import beat_scheduler_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int STEPS  = 16,
  parameter int SUBDIV = 4
) (
  input logic                  clk,
  input logic                  rst,
  beat_scheduler_if.slave      bus
);

  localparam longint unsigned LIMIT = 64'(CLK_HZ) * 64'd60;
  localparam longint unsigned MAX_INC = 64'(BPM_MAX) * 64'(SUBDIV);
  localparam int ACC_W = $clog2(LIMIT + MAX_INC);
  localparam int INC_W = $clog2(MAX_INC + 1);
  localparam int IDX_W = $clog2(STEPS);

  generate
    if (MAX_INC >= LIMIT) begin : g_bad_rate
      $error("beat_scheduler: fastest tempo would need more than one step per clock");
    end
    if ((STEPS < 2) || (STEPS > 256) || ((STEPS & (STEPS - 1)) != 0)) begin : g_bad_steps
      $error("beat_scheduler: STEPS must be a power of two in 2..256");
    end
    if ((SUBDIV < 1) || ((STEPS % SUBDIV) != 0)) begin : g_bad_subdiv
      $error("beat_scheduler: STEPS must be a multiple of SUBDIV");
    end
  endgenerate

  transport_e       state;
  logic [IDX_W-1:0] step_idx;
  logic [IDX_W-1:0] idx_next;
  logic [7:0]       bpm_active;
  logic             step_tick;
  logic             beat_tick;
  logic             bar_tick;
  logic             running;

  logic             nco_clr;
  logic             nco_en;
  logic             nco_wrap;
  logic [INC_W-1:0] nco_inc;

  // A play or stop pulse on this edge overrides accumulation, so a pause landing
  // exactly on a boundary leaves the accumulator untouched.
  assign nco_en  = (state == ST_RUNNING) && !bus.play && !bus.stop;
  assign nco_clr = bus.stop || ((state == ST_STOPPED) && bus.play);
  assign nco_inc = INC_W'(64'(bpm_active) * 64'(SUBDIV));

  // Power-of-two STEPS makes the natural wrap of the counter the modulo.
  assign idx_next = step_idx + 1'b1;

  step_rate_nco #(
    .LIMIT (LIMIT),
    .ACC_W (ACC_W),
    .INC_W (INC_W)
  ) u_nco (
    .clk  (clk),
    .rst  (rst),
    .clr  (nco_clr),
    .en   (nco_en),
    .inc  (nco_inc),
    .wrap (nco_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_STOPPED;
      step_idx   <= '0;
      bpm_active <= BPM_DEFAULT;
      step_tick  <= 1'b0;
      beat_tick  <= 1'b0;
      bar_tick   <= 1'b0;
      running    <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      beat_tick <= 1'b0;
      bar_tick  <= 1'b0;
      if (bus.stop) begin
        state    <= ST_STOPPED;
        step_idx <= '0;
        running  <= 1'b0;
      end else begin
        case (state)
          ST_STOPPED: begin
            if (bus.play) begin
              // Start always lands on a downbeat of step 0.
              state      <= ST_RUNNING;
              running    <= 1'b1;
              step_idx   <= '0;
              bpm_active <= clamp_bpm(bus.bpm);
              step_tick  <= 1'b1;
              beat_tick  <= 1'b1;
              bar_tick   <= 1'b1;
            end
          end
          ST_RUNNING: begin
            if (bus.play) begin
              state   <= ST_PAUSED;
              running <= 1'b0;
            end else if (nco_wrap) begin
              step_idx   <= idx_next;
              step_tick  <= 1'b1;
              beat_tick  <= ((int'(idx_next) % SUBDIV) == 0);
              bar_tick   <= (idx_next == '0);
              bpm_active <= clamp_bpm(bus.bpm);
            end
          end
          ST_PAUSED: begin
            if (bus.play) begin
              state   <= ST_RUNNING;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= ST_STOPPED;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.step_tick  = step_tick;
  assign bus.beat_tick  = beat_tick;
  assign bus.bar_tick   = bar_tick;
  assign bus.step_idx   = step_idx;
  assign bus.running    = running;
  assign bus.bpm_active = bpm_active;

endmodule

// File: tb/tb_beat_scheduler.sv
// tb/tb_beat_scheduler.sv - directed self-checking bench for beat_scheduler
module tb_beat_scheduler;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  beat_scheduler_if #(.STEPS(16)) bus ();

  beat_scheduler #(
    .CLK_HZ (100),
    .STEPS  (16),
    .SUBDIV (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bpm;
    logic [7:0] exp_active;
    int         exp_period;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic pulse_play();
    bus.play = 1'b1;
    tick();
    bus.play = 1'b0;
  endtask

  task automatic start(input logic [7:0] b);
    bus.bpm = b;
    pulse_play();
  endtask

  task automatic wait_step(output int n, input int budget);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.step_tick && n < budget);
    chk("step_seen", bus.step_tick, 1);
  endtask

  task automatic check_downbeat(input string tag);
    chk({tag, "_step_tick"}, bus.step_tick, 1);
    chk({tag, "_beat_tick"}, bus.beat_tick, 1);
    chk({tag, "_bar_tick"}, bus.bar_tick, 1);
    chk({tag, "_idx"}, bus.step_idx, 0);
    chk({tag, "_running"}, bus.running, 1);
  endtask

  initial begin
    int n;
    int total;
    int quiet;

    n_cmp  = 0;
    n_fail = 0;
    rst      = 1'b1;
    bus.bpm  = 8'd150;
    bus.play = 1'b0;
    bus.stop = 1'b0;

    vecs[0] = '{8'd150, 8'd150, 10};
    vecs[1] = '{8'd120, 8'd120, 13};
    vecs[2] = '{8'd100, 8'd100, 15};
    vecs[3] = '{8'd60,  8'd60,  25};
    vecs[4] = '{8'd0,   8'd5,   300};
    vecs[5] = '{8'd4,   8'd5,   300};
    vecs[6] = '{8'd5,   8'd5,   300};
    vecs[7] = '{8'd200, 8'd200, 8};
    vecs[8] = '{8'd201, 8'd200, 8};
    vecs[9] = '{8'd255, 8'd200, 8};

    // Reset values
    repeat (2) tick();
    chk("rst_idx", bus.step_idx, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_bpm_active", bus.bpm_active, 120);
    chk("rst_step_tick", bus.step_tick, 0);
    chk("rst_bar_tick", bus.bar_tick, 0);
    rst = 1'b0;
    tick();

    // Tempo table: latch/clamp and first step period from a fresh start
    for (int i = 0; i < 10; i++) begin
      do_stop();
      start(vecs[i].bpm);
      check_downbeat($sformatf("vec%0d_down", i));
      chk($sformatf("vec%0d_bpm_active", i), bus.bpm_active, vecs[i].exp_active);
      wait_step(n, 400);
      chk($sformatf("vec%0d_period", i), n, vecs[i].exp_period);
      chk($sformatf("vec%0d_idx", i), bus.step_idx, 1);
    end

    // One full bar at 150 bpm plus the wrap back to step 0
    do_stop();
    start(8'd150);
    check_downbeat("bar_down");
    for (int k = 1; k <= 16; k++) begin
      wait_step(n, 40);
      chk($sformatf("bar_period%0d", k), n, 10);
      chk($sformatf("bar_idx%0d", k), bus.step_idx, k % 16);
      chk($sformatf("bar_beat%0d", k), bus.beat_tick, (k % 4) == 0);
      chk($sformatf("bar_bar%0d", k), bus.bar_tick, (k % 16) == 0);
    end

    // 120 bpm: 12.5 clk per step alternates 13/12, exact over two bars
    do_stop();
    start(8'd120);
    total = 0;
    for (int k = 0; k < 16; k++) begin
      wait_step(n, 40);
      chk($sformatf("b120_period%0d", k), n, (k % 2 == 0) ? 13 : 12);
      total += n;
      if (k == 7) chk("b120_8step_total", total, 100);
    end
    chk("b120_2bar_total", total, 200);

    // Tempo change mid-step applies only at the next boundary
    do_stop();
    start(8'd150);
    wait_step(n, 40);
    repeat (3) tick();
    bus.bpm = 8'd200;
    chk("tc_active_before", bus.bpm_active, 150);
    wait_step(n, 40);
    chk("tc_current_period", n + 3, 10);
    chk("tc_active_after", bus.bpm_active, 200);
    wait_step(n, 40);
    chk("tc_new_period", n, 8);

    // Pause at step 5 after 2 accumulations, hold 50 clk, resume
    do_stop();
    start(8'd150);
    for (int k = 0; k < 5; k++) wait_step(n, 40);
    chk("pz_idx_at5", bus.step_idx, 5);
    repeat (2) tick();
    pulse_play();
    chk("pz_running", bus.running, 0);
    quiet = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      quiet += int'(bus.step_tick) + int'(bus.beat_tick) + int'(bus.bar_tick);
    end
    chk("pz_quiet", quiet, 0);
    chk("pz_idx_held", bus.step_idx, 5);
    pulse_play();
    chk("pz_resume_running", bus.running, 1);
    chk("pz_resume_no_strobe", bus.step_tick, 0);
    wait_step(n, 40);
    chk("pz_remaining", n, 8);
    chk("pz_idx6", bus.step_idx, 6);

    // Pause on the very edge of a boundary: boundary is not taken
    do_stop();
    start(8'd150);
    repeat (9) tick();
    pulse_play();
    chk("edge_no_strobe", bus.step_tick, 0);
    chk("edge_idx", bus.step_idx, 0);
    chk("edge_running", bus.running, 0);
    pulse_play();
    wait_step(n, 40);
    chk("edge_resume_period", n, 1);
    chk("edge_idx1", bus.step_idx, 1);

    // play and stop together at step 9: stop wins
    do_stop();
    start(8'd150);
    for (int k = 0; k < 9; k++) wait_step(n, 40);
    chk("ps_idx9", bus.step_idx, 9);
    repeat (4) tick();
    bus.play = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.play = 1'b0;
    bus.stop = 1'b0;
    chk("ps_running", bus.running, 0);
    chk("ps_idx", bus.step_idx, 0);
    chk("ps_no_strobe", bus.step_tick, 0);
    quiet = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      quiet += int'(bus.step_tick);
    end
    chk("ps_stopped_quiet", quiet, 0);
    start(8'd150);
    check_downbeat("ps_restart");
    wait_step(n, 40);
    chk("ps_restart_period", n, 10);

    // Asynchronous reset mid-run, asserted while strobes are high
    bus.bpm = 8'd200;
    wait_step(n, 40);
    wait_step(n, 40);
    chk("ar_pre_strobe", bus.step_tick, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_step_tick", bus.step_tick, 0);
    chk("ar_idx", bus.step_idx, 0);
    chk("ar_running", bus.running, 0);
    chk("ar_bpm_active", bus.bpm_active, 120);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_stays_stopped", bus.running, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
